// File: rtl/mvu_stream_top_if.sv
`default_nettype none
//==============================================================================
// mvu_stream_top_if -- activation, weight and result streams of the MVU | rev 1.0
//==============================================================================
interface mvu_stream_top_if #(
  parameter int unsigned S0_W = 8,
  parameter int unsigned S1_W = 16,
  parameter int unsigned M0_W = 32
) ();
  logic [S0_W-1:0] s0_axis_tdata;
  logic            s0_axis_tvalid;
  logic            s0_axis_tready;
  logic [S1_W-1:0] s1_axis_tdata;
  logic            s1_axis_tvalid;
  logic            s1_axis_tready;
  logic [M0_W-1:0] m0_axis_tdata;
  logic            m0_axis_tvalid;
  logic            m0_axis_tready;

  modport master (
    output s0_axis_tdata, s0_axis_tvalid, input s0_axis_tready,
    output s1_axis_tdata, s1_axis_tvalid, input s1_axis_tready,
    input  m0_axis_tdata, m0_axis_tvalid, output m0_axis_tready
  );

  modport slave (
    input  s0_axis_tdata, s0_axis_tvalid, output s0_axis_tready,
    input  s1_axis_tdata, s1_axis_tvalid, output s1_axis_tready,
    output m0_axis_tdata, m0_axis_tvalid, input m0_axis_tready
  );
endinterface
`default_nettype wire

// File: rtl/mvu_stream_top.sv
`default_nettype none
//==============================================================================
// mvu_stream_top -- streaming matrix-vector unit, activations reused per column | rev 1.0
//==============================================================================
module mvu_stream_top #(
  parameter int unsigned KDIM   = 2,
  parameter int unsigned IFMCH  = 4,
  parameter int unsigned OFMCH  = 4,
  parameter int unsigned SIMD   = 2,
  parameter int unsigned PE     = 2,
  parameter int unsigned TSRCI  = 4,
  parameter int unsigned TW     = 4,
  parameter int unsigned TDSTI  = 16,
  parameter logic [1:0]  OP_SGN = 2'b11
) (
  input  wire logic        clock,
  input  wire logic        resetn,
  mvu_stream_top_if.slave  bus
);
  localparam int unsigned c_matrix_w = KDIM * KDIM * IFMCH;
  localparam int unsigned c_nf       = OFMCH / PE;
  localparam int unsigned c_sf       = c_matrix_w / SIMD;
  localparam int unsigned c_sw       = (c_sf > 1) ? $clog2(c_sf) : 1;
  localparam int unsigned c_rw       = (c_nf > 1) ? $clog2(c_nf) : 1;
  localparam int unsigned c_aw       = SIMD * TSRCI;

  logic [c_sw-1:0]       s_q, s_d;
  logic [c_rw-1:0]       r_q, r_d;
  logic [c_aw-1:0]       buf_q [c_sf];
  logic [c_aw-1:0]       buf_d [c_sf];
  logic [TDSTI-1:0]      acc_q [PE];
  logic [TDSTI-1:0]      acc_d [PE];
  logic [PE*TDSTI-1:0]   out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic                  w_adv, w_first, w_fire, w_last_s, w_last_r;
  logic [c_aw-1:0]       w_act;
  logic [TDSTI-1:0]      w_prod [PE][SIMD];
  logic [TDSTI-1:0]      w_sum [PE];

  // Readies are gated by reset so nothing is taken while resetn is low.
  assign w_adv    = !out_valid_q || bus.m0_axis_tready;
  assign w_first  = (r_q == '0);
  assign w_fire   = resetn && w_adv && bus.s1_axis_tvalid && (!w_first || bus.s0_axis_tvalid);
  assign w_last_s = (s_q == c_sw'(c_sf - 1));
  assign w_last_r = (r_q == c_rw'(c_nf - 1));
  assign w_act    = w_first ? bus.s0_axis_tdata : buf_q[s_q];

  assign bus.s0_axis_tready = w_fire && w_first;
  assign bus.s1_axis_tready = w_fire;
  assign bus.m0_axis_tdata  = out_data_q;
  assign bus.m0_axis_tvalid = out_valid_q;

  for (genvar gp = 0; gp < PE; gp++) begin : g_pe
    for (genvar gl = 0; gl < SIMD; gl++) begin : g_lane
      logic [TSRCI-1:0] w_opa;
      logic [TW-1:0]    w_opb;
      assign w_opa = w_act[(SIMD-1-gl)*TSRCI +: TSRCI];
      assign w_opb = bus.s1_axis_tdata[((PE-1-gp)*SIMD + (SIMD-1-gl))*TW +: TW];

      if (TSRCI == 1 && TW == 1) begin : g_bin
        if (OP_SGN == 2'b00) begin : g_and
          assign w_prod[gp][gl] = {{(TDSTI-1){1'b0}}, w_opa & w_opb};
        end else if (OP_SGN == 2'b11) begin : g_xnor
          assign w_prod[gp][gl] = {{(TDSTI-1){1'b0}}, ~(w_opa ^ w_opb)};
        end else begin : g_illegal
          $fatal(1, "mvu_stream_top: binary operands need OP_SGN 00 or 11");
          assign w_prod[gp][gl] = '0;
        end
      end else if (TSRCI == 1) begin : g_act_bin
        logic [TDSTI-1:0] w_ext;
        assign w_ext = {{(TDSTI-TW){OP_SGN[0] & w_opb[TW-1]}}, w_opb};
        assign w_prod[gp][gl] = w_opa[0] ? w_ext : ((OP_SGN == 2'b11) ? ('0 - w_ext) : '0);
      end else if (TW == 1) begin : g_wgt_bin
        logic [TDSTI-1:0] w_ext;
        assign w_ext = {{(TDSTI-TSRCI){OP_SGN[1] & w_opa[TSRCI-1]}}, w_opa};
        assign w_prod[gp][gl] = w_opb[0] ? w_ext : ((OP_SGN == 2'b11) ? ('0 - w_ext) : '0);
      end else begin : g_mul
        logic [TDSTI-1:0] w_a_ext, w_b_ext;
        assign w_a_ext = {{(TDSTI-TSRCI){OP_SGN[1] & w_opa[TSRCI-1]}}, w_opa};
        assign w_b_ext = {{(TDSTI-TW){OP_SGN[0] & w_opb[TW-1]}}, w_opb};
        assign w_prod[gp][gl] = w_a_ext * w_b_ext;
      end
    end
  end

  // Accumulation restarts at the first beat of every output group.
  always_comb begin
    for (int p = 0; p < PE; p++) begin
      w_sum[p] = (s_q == '0) ? '0 : acc_q[p];
      for (int l = 0; l < SIMD; l++) begin
        w_sum[p] = w_sum[p] + w_prod[p][l];
      end
    end
  end

  always_comb begin
    s_d         = s_q;
    r_d         = r_q;
    buf_d       = buf_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !bus.m0_axis_tready;
    if (w_fire) begin
      acc_d = w_sum;
      if (w_first) begin
        buf_d[s_q] = bus.s0_axis_tdata;
      end
      if (w_last_s) begin
        s_d         = '0;
        r_d         = w_last_r ? '0 : r_q + 1'b1;
        out_valid_d = 1'b1;
        for (int p = 0; p < PE; p++) begin
          out_data_d[(PE-1-p)*TDSTI +: TDSTI] = w_sum[p];
        end
      end else begin
        s_d = s_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s_q         <= '0;
      r_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int p = 0; p < PE; p++) begin
        acc_q[p] <= '0;
      end
    end else begin
      s_q         <= s_d;
      r_q         <= r_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
    end
  end

  // Buffer contents only matter once written during the first group.
  always_ff @(posedge clock) begin
    buf_q <= buf_d;
  end
endmodule
`default_nettype wire

// File: tb/tb_mvu_stream_top.sv
`default_nettype none
//==============================================================================
// tb_mvu_stream_top -- scoreboard bench for mvu_stream_top | rev 1.0
//==============================================================================
module tb_mvu_stream_top;
  localparam int SF = 8;
  localparam int NF = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  mvu_stream_top_if #(.S0_W(8), .S1_W(16), .M0_W(32)) bus ();
  mvu_stream_top #(
    .KDIM(2), .IFMCH(4), .OFMCH(4), .SIMD(2), .PE(2),
    .TSRCI(4), .TW(4), .TDSTI(16), .OP_SGN(2'b11)
  ) dut (.clock(clock), .resetn(resetn), .bus(bus));

  mvu_stream_top_if #(.S0_W(8), .S1_W(16), .M0_W(32)) bus_sb ();
  mvu_stream_top #(
    .KDIM(1), .IFMCH(2), .OFMCH(2), .SIMD(2), .PE(2),
    .TSRCI(4), .TW(4), .TDSTI(16), .OP_SGN(2'b11)
  ) dut_sb (.clock(clock), .resetn(resetn), .bus(bus_sb));

  mvu_stream_top_if #(.S0_W(4), .S1_W(4), .M0_W(16)) bus_x ();
  mvu_stream_top #(
    .KDIM(1), .IFMCH(4), .OFMCH(1), .SIMD(4), .PE(1),
    .TSRCI(1), .TW(1), .TDSTI(16), .OP_SGN(2'b11)
  ) dut_x (.clock(clock), .resetn(resetn), .bus(bus_x));

  mvu_stream_top_if #(.S0_W(4), .S1_W(4), .M0_W(16)) bus_a ();
  mvu_stream_top #(
    .KDIM(1), .IFMCH(4), .OFMCH(1), .SIMD(4), .PE(1),
    .TSRCI(1), .TW(1), .TDSTI(16), .OP_SGN(2'b00)
  ) dut_a (.clock(clock), .resetn(resetn), .bus(bus_a));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  int col_a [16];
  int col_w [4][16];
  int sink_mode = 0;

  logic [3:0]  bin_a [4] = '{4'b1010, 4'b1111, 4'b0000, 4'b0110};
  logic [3:0]  bin_w [4] = '{4'b1001, 4'b1111, 4'b1111, 4'b0011};
  logic [15:0] xnor_exp [4] = '{16'd2, 16'd4, 16'd0, 16'd2};
  logic [15:0] and_exp  [4] = '{16'd1, 16'd4, 16'd0, 16'd1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] ref_dot(input int row);
    int sum;
    sum = 0;
    for (int k = 0; k < 16; k++) sum += col_a[k] * col_w[row][k];
    return 16'(sum);
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 16; k++) begin
      col_a[k] = int'($urandom_range(15, 0)) - 8;
      for (int r = 0; r < 4; r++) col_w[r][k] = int'($urandom_range(15, 0)) - 8;
    end
  endtask

  task automatic fill_const(input int a, input int w);
    for (int k = 0; k < 16; k++) begin
      col_a[k] = a;
      for (int r = 0; r < 4; r++) col_w[r][k] = w;
    end
  endtask

  // Called at posedge+1; max_beats < 0 drives the whole column.
  task automatic drive_column(input bit push, input int max_beats, input bit gaps);
    int beat;
    bit done;
    int budget;
    beat = 0;
    if (push) begin
      for (int r = 0; r < NF; r++) exp_q.push_back({ref_dot(2*r), ref_dot(2*r+1)});
    end
    for (int r = 0; r < NF; r++) begin
      for (int s = 0; s < SF; s++) begin
        if (beat == max_beats) begin
          bus.s0_axis_tvalid = 1'b0;
          bus.s1_axis_tvalid = 1'b0;
          return;
        end
        done   = 1'b0;
        budget = 0;
        bus.s1_axis_tdata = {4'(col_w[2*r][2*s]), 4'(col_w[2*r][2*s+1]),
                             4'(col_w[2*r+1][2*s]), 4'(col_w[2*r+1][2*s+1])};
        while (!done) begin
          bus.s1_axis_tvalid = gaps ? ($urandom_range(2, 0) != 0) : 1'b1;
          if (r == 0) begin
            bus.s0_axis_tdata  = {4'(col_a[2*s]), 4'(col_a[2*s+1])};
            bus.s0_axis_tvalid = gaps ? ($urandom_range(2, 0) != 0) : 1'b1;
          end else begin
            bus.s0_axis_tdata  = 8'($urandom);
            bus.s0_axis_tvalid = ($urandom_range(1, 0) == 1);
          end
          @(negedge clock);
          check("ready_needs_valid",
                {bus.s0_axis_tready & ~bus.s0_axis_tvalid, bus.s1_axis_tready & ~bus.s1_axis_tvalid}, 0);
          if (r == 0) check("first_ready_pair", bus.s0_axis_tready, bus.s1_axis_tready);
          else        check("reuse_s0_ready_low", bus.s0_axis_tready, 0);
          done = bus.s1_axis_tvalid && bus.s1_axis_tready;
          @(posedge clock); #1;
          if (done && s == SF-1) check("result_latency", bus.m0_axis_tvalid, 1);
          budget++;
          if (!done && budget > 300) begin
            check("beat_timeout", budget, 0);
            bus.s0_axis_tvalid = 1'b0;
            bus.s1_axis_tvalid = 1'b0;
            return;
          end
        end
        beat++;
      end
    end
    bus.s0_axis_tvalid = 1'b0;
    bus.s1_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.m0_axis_tvalid) && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_outstanding", exp_q.size(), 0);
  endtask

  // Result sink: 0 always ready, 1 random, 2 holds each result 5 cycles.
  initial begin
    int hold;
    hold = 0;
    bus.m0_axis_tready = 1'b1;
    forever begin
      @(posedge clock); #1;
      case (sink_mode)
        0: bus.m0_axis_tready = 1'b1;
        1: bus.m0_axis_tready = ($urandom_range(3, 0) != 0);
        default: begin
          if (bus.m0_axis_tvalid && hold < 5) begin
            bus.m0_axis_tready = 1'b0;
            hold++;
          end else begin
            bus.m0_axis_tready = 1'b1;
            hold = 0;
          end
        end
      endcase
    end
  end

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  always @(negedge clock) begin
    if (!resetn) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {bus.m0_axis_tvalid, bus.m0_axis_tdata}, {1'b1, prev_data});
      if (bus.m0_axis_tvalid && !bus.m0_axis_tready) check("stall_s1_ready_low", bus.s1_axis_tready, 0);
      if (bus.m0_axis_tvalid && bus.m0_axis_tready) begin
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else check("m0_tdata", bus.m0_axis_tdata, exp_q.pop_front());
      end
      prev_stall <= bus.m0_axis_tvalid && !bus.m0_axis_tready;
      prev_data  <= bus.m0_axis_tdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.s0_axis_tdata = '0;  bus.s0_axis_tvalid = 1'b1;
    bus.s1_axis_tdata = '0;  bus.s1_axis_tvalid = 1'b1;
    bus_sb.s0_axis_tdata = '0; bus_sb.s0_axis_tvalid = 1'b0;
    bus_sb.s1_axis_tdata = '0; bus_sb.s1_axis_tvalid = 1'b0; bus_sb.m0_axis_tready = 1'b1;
    bus_x.s0_axis_tdata = '0;  bus_x.s0_axis_tvalid = 1'b0;
    bus_x.s1_axis_tdata = '0;  bus_x.s1_axis_tvalid = 1'b0;  bus_x.m0_axis_tready = 1'b1;
    bus_a.s0_axis_tdata = '0;  bus_a.s0_axis_tvalid = 1'b0;
    bus_a.s1_axis_tdata = '0;  bus_a.s1_axis_tvalid = 1'b0;  bus_a.m0_axis_tready = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_m0_tvalid", bus.m0_axis_tvalid, 0);
    check("reset_m0_tdata", bus.m0_axis_tdata, 0);
    check("reset_readys", {bus.s0_axis_tready, bus.s1_axis_tready}, 0);
    @(posedge clock); #1;
    bus.s0_axis_tvalid = 1'b0;
    bus.s1_axis_tvalid = 1'b0;
    resetn = 1'b1;

    // Hand-computed columns.
    fill_const(-8, -8);                 // 16 * 64 = 1024
    exp_q.push_back(32'h0400_0400); exp_q.push_back(32'h0400_0400);
    drive_column(0, -1, 0);
    fill_const(7, -8);                  // 16 * -56 = -896
    exp_q.push_back(32'hFC80_FC80); exp_q.push_back(32'hFC80_FC80);
    drive_column(0, -1, 0);
    for (int k = 0; k < 16; k++) begin  // rows weighted 1..4 over four ones
      col_a[k] = (k < 4) ? 1 : 0;
      for (int r = 0; r < 4; r++) col_w[r][k] = r + 1;
    end
    exp_q.push_back(32'h0004_0008); exp_q.push_back(32'h000C_0010);
    drive_column(0, -1, 0);
    for (int k = 0; k < 16; k++) begin  // only element 13 (beat 6, lane 1) contributes
      col_a[k] = (k == 13) ? 1 : 0;
      for (int r = 0; r < 4; r++) col_w[r][k] = (k == 13) ? r - 4 : 7;
    end
    exp_q.push_back(32'hFFFC_FFFD); exp_q.push_back(32'hFFFE_FFFF);
    drive_column(0, -1, 0);
    for (int c = 0; c < 2; c++) begin
      fill_random();
      drive_column(1, -1, 0);
    end
    wait_drain();

    sink_mode = 1;
    for (int c = 0; c < 5; c++) begin
      fill_random();
      drive_column(1, -1, 1);
    end
    wait_drain();

    sink_mode = 2;
    for (int c = 0; c < 3; c++) begin
      fill_random();
      drive_column(1, -1, 0);
    end
    wait_drain();
    sink_mode = 0;

    // Abort a column after three beats.
    fill_random();
    drive_column(0, 3, 0);
    resetn = 1'b0;
    bus.s0_axis_tvalid = 1'b1;
    bus.s1_axis_tvalid = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("midreset_m0", {bus.m0_axis_tvalid, bus.m0_axis_tdata}, 0);
      check("midreset_readys", {bus.s0_axis_tready, bus.s1_axis_tready}, 0);
    end
    @(posedge clock); #1;
    bus.s0_axis_tvalid = 1'b0;
    bus.s1_axis_tvalid = 1'b0;
    resetn = 1'b1;
    fill_random();
    drive_column(1, -1, 0);
    wait_drain();

    // Single-beat unit: A={3,-2}, W0={1,1}, W1={-1,2} -> {1, -7}.
    @(posedge clock); #1;
    bus_sb.s0_axis_tdata = 8'h3E;
    bus_sb.s1_axis_tdata = 16'h11F2;
    bus_sb.s0_axis_tvalid = 1'b1;
    bus_sb.s1_axis_tvalid = 1'b1;
    @(negedge clock);
    check("sb_readys", {bus_sb.s0_axis_tready, bus_sb.s1_axis_tready}, 2'b11);
    @(posedge clock); #1;
    bus_sb.s0_axis_tvalid = 1'b0;
    bus_sb.s1_axis_tvalid = 1'b0;
    check("sb_tvalid", bus_sb.m0_axis_tvalid, 1);
    check("sb_tdata", bus_sb.m0_axis_tdata, 32'h0001_FFF9);
    @(posedge clock); #1;
    check("sb_tvalid_clear", bus_sb.m0_axis_tvalid, 0);

    // Binary units share stimulus: XNOR vs AND.
    for (int i = 0; i < 4; i++) begin
      bus_x.s0_axis_tdata = bin_a[i];  bus_x.s1_axis_tdata = bin_w[i];
      bus_a.s0_axis_tdata = bin_a[i];  bus_a.s1_axis_tdata = bin_w[i];
      bus_x.s0_axis_tvalid = 1'b1;     bus_x.s1_axis_tvalid = 1'b1;
      bus_a.s0_axis_tvalid = 1'b1;     bus_a.s1_axis_tvalid = 1'b1;
      @(negedge clock);
      check("bin_readys", {bus_x.s1_axis_tready, bus_a.s1_axis_tready}, 2'b11);
      @(posedge clock); #1;
      bus_x.s0_axis_tvalid = 1'b0;     bus_x.s1_axis_tvalid = 1'b0;
      bus_a.s0_axis_tvalid = 1'b0;     bus_a.s1_axis_tvalid = 1'b0;
      check("xnor_result", {bus_x.m0_axis_tvalid, bus_x.m0_axis_tdata}, {1'b1, xnor_exp[i]});
      check("and_result", {bus_a.m0_axis_tvalid, bus_a.m0_axis_tdata}, {1'b1, and_exp[i]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
